ti_share_decoder: RTL

Share-recombination back end of the threshold-implementation S-box datapath. Accepts NSHARES-share masked 4-bit S-box outputs, registers every share before any recombination (glitch barrier), XOR-unmasks them, packs nibble pairs into bytes, and delivers the bytes over a valid/ready interface with frame-end flushing and a byte counter. It sits after the last registered TI S-box share stage and feeds the unmasked result port.

---
 rtl/ti_pkg.sv | 13 +
 rtl/ti_share_xor.sv | 20 ++
 rtl/ti_share_decoder.sv | 118 +++++++++++
 3 files changed

// File: rtl/ti_pkg.sv
// Types and constants shared by the threshold-implementation S-box components.
package ti_pkg;

  localparam int NW = 4;

  typedef logic [NW-1:0] nibble_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } asm_state_t;

endpackage

// File: rtl/ti_share_xor.sv
// Combinational XOR recombination of Boolean shares. Only ever fed from
// registered shares so no unregistered share mixing reaches downstream logic.
module ti_share_xor
  import ti_pkg::*;
#(
  parameter int NSHARES = 3
) (
  input  logic [NSHARES*NW-1:0] shares,
  output nibble_t               nib
);

  // fold every share into one unmasked nibble
  always_comb begin
    nib = '0;
    for (int i = 0; i < NSHARES; i++) begin
      nib = nib ^ shares[i*NW +: NW];
    end
  end

endmodule

// File: rtl/ti_share_decoder.sv
// Share-recombination back end: registers the masked shares, unmasks them,
// pairs nibbles into bytes per frame and delivers bytes over valid/ready.
//
//   state | meaning
//   ------+-------------------------------------------
//   EMPTY | no low nibble pending; next nibble is low
//   HALF  | low nibble held in lo_q; next one completes
module ti_share_decoder
  import ti_pkg::*;
#(
  parameter int NSHARES = 3,
  parameter int NW      = 4,
  parameter int CNTW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSHARES*NW-1:0] in_shares,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*NW-1:0]       out_data,
  output logic                  out_odd,
  output logic                  out_last,
  output logic [CNTW-1:0]       byte_cnt
);

  logic                  s1_v;
  logic                  s1_last;
  logic [NSHARES*NW-1:0] s1_sh;
  nibble_t               nib;
  nibble_t               lo_q;
  asm_state_t            state;

  logic                  out_free;
  logic                  s1_emit;
  logic                  s1_consume;
  logic                  accept;

  // a nibble that only becomes the low half never needs the output register
  assign out_free   = !out_valid || out_ready;
  assign s1_emit    = s1_v && ((state == HALF) || s1_last);
  assign s1_consume = s1_v && (!s1_emit || out_free);
  assign in_ready   = !s1_v || s1_consume;
  assign accept     = in_valid && in_ready;

  // glitch barrier: shares are captured untouched, no cross-share logic ahead of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_sh   <= '0;
    end else if (accept) begin
      s1_v    <= 1'b1;
      s1_last <= in_last;
      s1_sh   <= in_shares;
    end else if (s1_consume) begin
      s1_v    <= 1'b0;
    end
  end

  ti_share_xor #(
    .NSHARES (NSHARES)
  ) u_xor (
    .shares (s1_sh),
    .nib    (nib)
  );

  // nibble pairing FSM with the registered output byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      lo_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_odd   <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (s1_consume) begin
        case (state)
          EMPTY: begin
            if (s1_last) begin
              out_valid <= 1'b1;
              out_data  <= {{NW{1'b0}}, nib};
              out_odd   <= 1'b1;
              out_last  <= 1'b1;
            end else begin
              lo_q  <= nib;
              state <= HALF;
            end
          end
          HALF: begin
            out_valid <= 1'b1;
            out_data  <= {nib, lo_q};
            out_odd   <= 1'b0;
            out_last  <= s1_last;
            state     <= EMPTY;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  // delivered-byte counter, sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
    end else if (out_valid && out_ready && (byte_cnt != {CNTW{1'b1}})) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

endmodule
